// File: rtl/xillybus_read_source.sv
// xillybus_read_source: counter-frame generator feeding the Xillybus read_32 pipe through a prefetch FIFO
module xillybus_read_source #(
  parameter int          DEPTH    = 16,
  parameter logic [23:0] LED_HOLD = 24'd1250000
) (
  input  logic        bus_clk,
  input  logic        PCIE_PERST_B_LS,
  input  logic        user_r_read_32_open,
  input  logic        user_r_read_32_rden,
  output logic [31:0] user_r_read_32_data,
  output logic        user_r_read_32_empty,
  output logic        user_r_read_32_eof,
  input  logic [15:0] frame_words,
  input  logic [31:0] seed,
  output logic [31:0] words_sent,
  output logic        proto_err,
  output logic        led_activity
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, EOF_S} state_t;
  state_t state, state_nx;
  logic          open_q, rise, fall, push, pop, full;
  logic [AW:0]   count;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [31:0]   gen;
  logic [15:0]   remaining;
  logic [23:0]   led_cnt;
  logic [31:0]   mem [DEPTH];
  assign rise = user_r_read_32_open & ~open_q;
  assign fall = ~user_r_read_32_open & open_q;
  assign full = count == (AW+1)'(DEPTH);
  assign user_r_read_32_empty = count == '0;
  assign pop = user_r_read_32_rden & ~user_r_read_32_empty;
  assign push = state == RUN & ~full & ~fall;
  assign led_activity = led_cnt != '0;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = rise ? (frame_words == '0 ? EOF_S : RUN) : IDLE;
      RUN:     state_nx = push && remaining == 16'd1 ? DRAIN : RUN;
      DRAIN:   state_nx = user_r_read_32_empty ? EOF_S : DRAIN;
      default: state_nx = EOF_S;
    endcase
    if (fall) state_nx = IDLE;
  end
  always_ff @(posedge bus_clk)
    if (push) mem[wr_ptr] <= gen;
  always_ff @(posedge bus_clk or negedge PCIE_PERST_B_LS) begin
    if (!PCIE_PERST_B_LS) begin
      state               <= IDLE;
      open_q              <= 1'b0;
      count               <= '0;
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      gen                 <= '0;
      remaining           <= '0;
      led_cnt             <= '0;
      user_r_read_32_data <= '0;
      user_r_read_32_eof  <= 1'b0;
      words_sent          <= '0;
      proto_err           <= 1'b0;
    end else begin
      open_q             <= user_r_read_32_open;
      state              <= state_nx;
      user_r_read_32_eof <= state == EOF_S & ~fall;
      proto_err          <= proto_err | (user_r_read_32_rden & user_r_read_32_empty);
      if (state == IDLE && rise) begin
        gen       <= seed;
        remaining <= frame_words;
      end else if (push) begin
        gen       <= gen + 32'd1;
        remaining <= remaining - 16'd1;
      end
      // a closing file discards prefetched words, but a pop on that same edge still delivers
      if (fall) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        count  <= count + (AW+1)'(push) - (AW+1)'(pop);
        wr_ptr <= wr_ptr + AW'(push);
        rd_ptr <= rd_ptr + AW'(pop);
      end
      if (pop) begin
        user_r_read_32_data <= mem[rd_ptr];
        words_sent          <= words_sent + 32'd1;
        led_cnt             <= LED_HOLD;
      end else if (led_activity) begin
        led_cnt <= led_cnt - 24'd1;
      end
    end
  end
endmodule

// File: tb/tb_xillybus_read_source.sv
// tb_xillybus_read_source: randomized frames checked by a word-sequence scoreboard
module tb_xillybus_read_source;
  logic        clk = 0, rst_n = 0, open = 0, rden = 0;
  logic [15:0] fw = 0;
  logic [31:0] seed = 0;
  logic [31:0] data, words_sent;
  logic        empty, eof, proto_err, led;
  int          tests = 0, fails = 0, cyc;
  logic [31:0] exp_q[$];
  logic [31:0] ws_model = 0;
  always #5 clk = ~clk;
  xillybus_read_source #(.DEPTH(16), .LED_HOLD(24'd20)) dut (
    .bus_clk(clk), .PCIE_PERST_B_LS(rst_n),
    .user_r_read_32_open(open), .user_r_read_32_rden(rden),
    .user_r_read_32_data(data), .user_r_read_32_empty(empty), .user_r_read_32_eof(eof),
    .frame_words(fw), .seed(seed), .words_sent(words_sent),
    .proto_err(proto_err), .led_activity(led)
  );
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  // monitor: every accepted pop must deliver the oldest outstanding word of the frame
  always begin
    logic pv;
    @(posedge clk);
    pv = rden && !empty && rst_n;
    #1;
    if (pv) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pop: got %h expected no word", data);
      end else check("data", data, exp_q.pop_front());
      ws_model++;
      check("led_on", {31'd0, led}, 32'd1);
    end
  end
  task automatic check_reset();
    check("rst_data", data, 0);
    check("rst_empty", {31'd0, empty}, 1);
    check("rst_eof", {31'd0, eof}, 0);
    check("rst_words", words_sent, 0);
    check("rst_proto", {31'd0, proto_err}, 0);
    check("rst_led", {31'd0, led}, 0);
  endtask
  task automatic open_frame(input logic [31:0] s, input int n);
    @(negedge clk);
    seed = s;
    fw = 16'(n);
    open = 1;
    for (int i = 0; i < n; i++) exp_q.push_back(s + 32'(i));
    @(negedge clk);
    check("empty_c1", {31'd0, empty}, 1);
    @(negedge clk);
    if (n != 0) check("empty_c2", {31'd0, empty}, 0);
    else check("eof_c2", {31'd0, eof}, 1);
  endtask
  task automatic read_frame(input int prob, input int stop_at, output int cycles);
    cycles = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() <= stop_at || cycles >= 3000) break;
      rden = !empty && ($urandom_range(99) < prob);
      cycles++;
    end
    rden = 0;
    if (cycles >= 3000) begin
      tests++;
      fails++;
      $display("FAIL read_timeout: got %0d words left expected %0d", exp_q.size(), stop_at);
    end
  endtask
  task automatic finish_frame();
    repeat (3) @(negedge clk);
    check("eof_end", {31'd0, eof}, 1);
    check("empty_end", {31'd0, empty}, 1);
    check("words_sent", words_sent, ws_model);
    check("proto_ok", {31'd0, proto_err}, 0);
    check("left_words", exp_q.size(), 0);
  endtask
  task automatic close();
    open = 0;
    @(negedge clk);
    check("close_empty", {31'd0, empty}, 1);
    check("close_eof", {31'd0, eof}, 0);
    exp_q.delete();
    @(negedge clk);
  endtask
  initial begin
    logic [31:0] held;
    repeat (3) @(negedge clk);
    check_reset();
    rst_n = 1;
    open_frame(32'h100, 5);
    read_frame(100, 0, cyc);
    finish_frame();
    close();
    open_frame(32'h1000, 40);
    repeat (50) @(negedge clk);
    check("t2_full_empty", {31'd0, empty}, 0);
    read_frame(100, 0, cyc);
    check("t2_no_gaps", cyc, 40);
    finish_frame();
    close();
    open_frame(32'hFFFFFFFE, 4);
    read_frame(70, 0, cyc);
    finish_frame();
    close();
    open_frame(32'h55, 0);
    repeat (3) begin
      @(negedge clk);
      check("t4_empty", {31'd0, empty}, 1);
    end
    check("t4_eof", {31'd0, eof}, 1);
    close();
    open_frame(32'h5000, 100);
    read_frame(60, 90, cyc);
    close();
    open_frame(32'd7, 3);
    read_frame(100, 0, cyc);
    finish_frame();
    close();
    for (int k = 0; k < 6; k++) begin
      open_frame($urandom, $urandom_range(1, 30));
      read_frame($urandom_range(30, 100), 0, cyc);
      finish_frame();
      close();
    end
    repeat (25) @(negedge clk);
    check("led_off", {31'd0, led}, 0);
    held = data;
    rden = 1;
    @(negedge clk);
    rden = 0;
    check("proto_set", {31'd0, proto_err}, 1);
    check("proto_words", words_sent, ws_model);
    check("proto_data", data, held);
    repeat (2) @(negedge clk);
    check("proto_sticky", {31'd0, proto_err}, 1);
    open_frame(32'h9000, 50);
    read_frame(100, 40, cyc);
    #3 rst_n = 0;
    #1 check_reset();
    ws_model = 0;
    exp_q.delete();
    open = 0;
    @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
    open_frame(32'h42, 3);
    read_frame(80, 0, cyc);
    finish_frame();
    close();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
